// File: rtl/encoder_16_to_4.sv
// Registered 16-to-4 priority encoder with zero and multi-hot flags.
// Index, valid and multi are captured together so they never mix samples.
module encoder_16_to_4 #(
   parameter int MSB_PRIORITY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] i,
   output logic [3:0]  o,
   output logic        valid,
   output logic        multi
);

   logic [3:0] idx;
   logic       any_set;
   logic       multi_set;

   logic [3:0] o_d, o_q;
   logic       valid_d, valid_q;
   logic       multi_d, multi_q;

   // Last match in scan order wins, so scan direction sets the priority.
   always_comb begin
      idx = 4'd0;
      if (MSB_PRIORITY != 0) begin
         for (int k = 0; k < 16; k++) begin
            if (i[k]) idx = 4'(k);
         end
      end else begin
         for (int k = 15; k >= 0; k--) begin
            if (i[k]) idx = 4'(k);
         end
      end
   end

   assign any_set   = |i;
   assign multi_set = |(i & (i - 16'd1));

   always_comb begin
      o_d     = o_q;
      valid_d = valid_q;
      multi_d = multi_q;
      if (en) begin
         o_d     = idx;
         valid_d = any_set;
         multi_d = multi_set;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_q     <= 4'd0;
         valid_q <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         o_q     <= o_d;
         valid_q <= valid_d;
         multi_q <= multi_d;
      end
   end

   assign o     = o_q;
   assign valid = valid_q;
   assign multi = multi_q;

endmodule

// File: tb/tb_encoder_16_to_4.sv
// Bench for encoder_16_to_4: both priority settings driven in parallel.
// Table vectors, hand sequences for hold/reset, then a random model check.
module tb_encoder_16_to_4;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [15:0] i;
   logic [3:0]  o_h, o_l;
   logic        valid_h, valid_l;
   logic        multi_h, multi_l;

   int pass_cnt = 0;
   int total_cnt = 0;

   encoder_16_to_4 #(.MSB_PRIORITY(1)) dut_h (
      .clk(clk), .rst_n(rst_n), .en(en), .i(i),
      .o(o_h), .valid(valid_h), .multi(multi_h)
   );

   encoder_16_to_4 #(.MSB_PRIORITY(0)) dut_l (
      .clk(clk), .rst_n(rst_n), .en(en), .i(i),
      .o(o_l), .valid(valid_l), .multi(multi_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] vin;
      logic [3:0]  exp_h;
      logic [3:0]  exp_l;
      logic        exp_v;
      logic        exp_m;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic check_all(input string name, input logic [3:0] eh,
                            input logic [3:0] el, input logic ev,
                            input logic em);
      check({name, " o msb"}, int'(o_h), int'(eh));
      check({name, " o lsb"}, int'(o_l), int'(el));
      check({name, " valid"}, int'({valid_h, valid_l}), int'({ev, ev}));
      check({name, " multi"}, int'({multi_h, multi_l}), int'({em, em}));
   endtask

   task automatic step(input logic e, input logic [15:0] v);
      en = e;
      i  = v;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] ref_hi(input logic [15:0] v);
      for (int k = 15; k >= 0; k--) if (v[k]) return 4'(k);
      return 4'd0;
   endfunction

   function automatic logic [3:0] ref_lo(input logic [15:0] v);
      for (int k = 0; k < 16; k++) if (v[k]) return 4'(k);
      return 4'd0;
   endfunction

   logic [3:0]  m_h, m_l;
   logic        m_v, m_m;
   logic [15:0] rv;
   logic        re;

   initial begin
      for (int k = 0; k < 16; k++) begin
         vecs[k].vin   = 16'h0001 << k;
         vecs[k].exp_h = 4'(k);
         vecs[k].exp_l = 4'(k);
         vecs[k].exp_v = 1'b1;
         vecs[k].exp_m = 1'b0;
      end
      vecs[16] = '{16'h0000, 4'd0,  4'd0, 1'b0, 1'b0};
      vecs[17] = '{16'h8001, 4'd15, 4'd0, 1'b1, 1'b1};
      vecs[18] = '{16'h0140, 4'd8,  4'd6, 1'b1, 1'b1};

      rst_n = 1'b0;
      en    = 1'b1;
      i     = 16'hffff;
      repeat (3) @(posedge clk);
      #1;
      check_all("reset", 4'd0, 4'd0, 1'b0, 1'b0);
      rst_n = 1'b1;

      foreach (vecs[n]) begin
         step(1'b1, vecs[n].vin);
         check_all($sformatf("vec%0d", n), vecs[n].exp_h, vecs[n].exp_l,
                   vecs[n].exp_v, vecs[n].exp_m);
      end

      // Enable hold
      step(1'b1, 16'h0020);
      check_all("hold cap", 4'd5, 4'd5, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         step(1'b0, 16'h4000);
         check_all($sformatf("hold%0d", c), 4'd5, 4'd5, 1'b1, 1'b0);
      end
      step(1'b1, 16'h4000);
      check_all("hold rel", 4'd14, 4'd14, 1'b1, 1'b0);

      // Async reset between edges
      step(1'b1, 16'h0200);
      check_all("pre rst", 4'd9, 4'd9, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async rst", 4'd0, 4'd0, 1'b0, 1'b0);
      step(1'b1, 16'hffff);
      step(1'b1, 16'hffff);
      check_all("rst hold", 4'd0, 4'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step(1'b1, 16'h0004);
      check_all("post rst", 4'd2, 4'd2, 1'b1, 1'b0);

      // Random regression against reference model
      m_h = 4'd0; m_l = 4'd0; m_v = 1'b0; m_m = 1'b0;
      for (int r = 0; r < 1000; r++) begin
         case ($urandom_range(0, 3))
            0: rv = 16'h0000;
            1: rv = 16'h0001 << $urandom_range(0, 15);
            default: rv = 16'($urandom);
         endcase
         re = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (re) begin
            m_h = ref_hi(rv);
            m_l = ref_lo(rv);
            m_v = (rv != 16'h0000);
            m_m = ($countones(rv) >= 2);
         end
         step(re, rv);
         check_all($sformatf("rnd%0d", r), m_h, m_l, m_v, m_m);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
